ls192_pulse_driver: RTL
=======================

Name: ls192_pulse_driver

Overview:
- Synchronous-clocked controller that drives the asynchronous pin interface of the 74LS192-style presettable BCD up/down counter: cpu, cpd, pl_n, mr and p3..p0.
- Accepts commands over a valid/ready handshake: count up N, count down N, parallel load, master reset. Expands each command into correctly shaped pin pulses.
- Keeps a shadow BCD count of what the counter should hold, plus wrap indications.
- Sits between Basys3 control logic (switches, FSMs) and the 74LS192 library model or a physical part.

Parameters:
- PULSE_LOW, 2, cycles an active pulse is held (cpu/cpd low, pl_n low, mr high); must be >= 1.
- PULSE_GAP, 2, idle-level cycles after each pulse before the next pulse or completion; must be >= 1.
- STEP_W, 8, width of the step-count field.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  driver can accept a command
- cmd_op  input  2  00 up, 01 down, 10 load, 11 clear
- cmd_steps  input  STEP_W  pulse count for up/down; ignored otherwise
- cmd_data  input  4  preset value for load
- busy  output  1  a command is in progress
- done  output  1  one-cycle completion pulse
- cpu  output  1  count-up clock to counter, idle high
- cpd  output  1  count-down clock to counter, idle high
- pl_n  output  1  parallel load, active low
- mr  output  1  master reset, active high
- p  output  4  preset data {p3,p2,p1,p0}
- shadow  output  4  expected counter value
- wrap_up  output  1  one-cycle pulse when an up step takes shadow from 9 to 0
- wrap_dn  output  1  one-cycle pulse when a down step takes shadow from 0 to 9

Behaviour:
- Reset (asynchronous, any time, including mid-pulse):
  - Outputs: cpu=1, cpd=1, pl_n=1, mr=0, p=0, shadow=0, busy=0, done=0, wrap_up=0, wrap_dn=0.
  - cmd_ready=1 after reset.
  - Any in-flight command is discarded. No pulse is extended or completed after rst_n rises.
- FSM states: IDLE, ACTIVE, GAP, DONE.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on a rising edge with cmd_valid && cmd_ready. op, steps and data are captured on that edge.
  - Inputs are ignored while busy.
- Up/down command, steps=0: IDLE -> DONE. No pin activity; done is high in the cycle after acceptance.
- Up/down command, steps>0:
  - IDLE -> ACTIVE. cpu (up) or cpd (down) goes low starting the cycle after acceptance and stays low for PULSE_LOW cycles. The other clock pin stays high throughout.
  - ACTIVE -> GAP: the pin returns high. This rising edge is the counter's count edge. shadow updates in that same cycle.
  - GAP lasts PULSE_GAP cycles, then goes to ACTIVE if steps remain, otherwise to DONE.
  - Total busy time = steps*(PULSE_LOW+PULSE_GAP) cycles. done follows in the next cycle.
- Shadow arithmetic:
  - Up: shadow >= 9 becomes 0 (wrap_up asserted only when shadow was exactly 9); otherwise +1.
  - Down: 0 becomes 9 (wrap_dn asserted); shadow > 9 becomes 9 with no wrap; otherwise -1.
- Load:
  - p=cmd_data is driven from the cycle after acceptance. pl_n is low for PULSE_LOW cycles, then GAP, then DONE.
  - shadow takes the raw cmd_data, non-BCD 10..15 included, in the first pl_n-low cycle.
  - p holds its value until the next load or reset.
- Clear: mr is high for PULSE_LOW cycles, then GAP, then DONE. shadow=0 in the first mr-high cycle.
- DONE: lasts one cycle with done=1, busy=0, cmd_ready=0, then returns to IDLE.
- busy=1 in ACTIVE and GAP.
- Glitch freedom:
  - cpu, cpd, pl_n and mr are driven directly from flops, never from combinational decode.
  - At most one of the four pins is in its active state at any time.

Decomposition:
- Package ls192_drv_pkg holds:
  - op-code constants OP_UP, OP_DOWN, OP_LOAD, OP_CLEAR;
  - FSM state encoding;
  - BCD_MAX=9.
- Sub-module ls192_pulse_timer: loadable down-counter sized to max(PULSE_LOW, PULSE_GAP). Has load, value and expire ports. It is reused for both the ACTIVE and GAP phases.

Test Plan (PULSE_LOW=2, PULSE_GAP=2):
1. Assert rst_n=0 for 3 cycles, release -> all outputs at their reset values, cmd_ready=1, no pin toggles for 10 idle cycles.
2. LOAD data=7, then UP steps=3 ->
   - load: pl_n low 2 cycles, p=7, shadow=7, done one cycle;
   - up: exactly 3 cpu low pulses of 2 cycles each;
   - shadow 8, 9, 0; wrap_up once, on the third step;
   - done 13 cycles after acceptance; cpd stays 1 throughout.
3. CLEAR, then DOWN steps=2 -> mr high 2 cycles, shadow=0, then shadow 9, 8; wrap_dn once; 2 cpd pulses.
4. UP steps=0 -> no pin activity, done=1 in cycle 1 after acceptance, shadow unchanged.
5. Hold cmd_valid high with a new command while busy -> not accepted until IDLE. Then drop rst_n mid cpu-low -> cpu=1 and busy=0 immediately; shadow=0.
6. LOAD data=12, UP 1 -> shadow 0, no wrap_up. LOAD 12, DOWN 1 -> shadow 9, no wrap_dn.

Source files
------------

// File: rtl/ls192_drv_pkg.sv
// Shared definitions for the 74LS192 pulse driver:
// op-codes, FSM state encoding and BCD step helpers.
package ls192_drv_pkg;

  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP,
    S_DONE
  } state_t;

  // Non-BCD values fold to 0 going up, 9 going down.
  function automatic logic [3:0] bcd_up(input logic [3:0] v);
    return (v >= BCD_MAX) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dn(input logic [3:0] v);
    if (v == 4'd0 || v > BCD_MAX) return BCD_MAX;
    return v - 4'd1;
  endfunction

endpackage

// File: rtl/ls192_pulse_timer.sv
// Loadable down-counter timing pulse and gap phases.
// Ports: load/value preset the count; expire flags the last cycle.
module ls192_pulse_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/ls192_pulse_driver.sv
// Command-driven pin sequencer for a 74LS192 BCD counter.
// Ports: cmd_* handshake in; cpu/cpd/pl_n/mr/p pins, shadow/wrap out.
module ls192_pulse_driver
  import ls192_drv_pkg::*;
#(
  parameter int PULSE_LOW = 2,
  parameter int PULSE_GAP = 2,
  parameter int STEP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [3:0]        cmd_data,
  output logic              busy,
  output logic              done,
  output logic              cpu,
  output logic              cpd,
  output logic              pl_n,
  output logic              mr,
  output logic [3:0]        p,
  output logic [3:0]        shadow,
  output logic              wrap_up,
  output logic              wrap_dn
);

  localparam int MAXC =
    (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] LOW_V = TW'(PULSE_LOW - 1);
  localparam logic [TW-1:0] GAP_V = TW'(PULSE_GAP - 1);

  state_t            state, state_d;
  logic [1:0]        op_q, op_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              cpu_d, cpd_d, pl_d, mr_d;
  logic [3:0]        p_d, sh_d;
  logic              wu_d, wd_d;
  logic              tmr_load, tmr_exp;
  logic [TW-1:0]     tmr_val;

  ls192_pulse_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_val),
    .expire (tmr_exp)
  );

  always_comb begin
    state_d  = state;
    op_d     = op_q;
    steps_d  = steps_q;
    cpu_d    = cpu;
    cpd_d    = cpd;
    pl_d     = pl_n;
    mr_d     = mr;
    p_d      = p;
    sh_d     = shadow;
    wu_d     = 1'b0;
    wd_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = LOW_V;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          steps_d  = '0;
          tmr_load = 1'b1;
          state_d  = S_ACTIVE;
          unique case (1'b1)
            (cmd_op == OP_UP),
            (cmd_op == OP_DOWN): begin
              if (cmd_steps == '0) begin
                state_d = S_DONE;
              end else begin
                steps_d = cmd_steps;
                if (cmd_op == OP_UP) cpu_d = 1'b0;
                else                 cpd_d = 1'b0;
              end
            end
            (cmd_op == OP_LOAD): begin
              pl_d = 1'b0;
              p_d  = cmd_data;
              sh_d = cmd_data;
            end
            default: begin
              mr_d = 1'b1;
              sh_d = 4'd0;
            end
          endcase
        end
      end
      S_ACTIVE: begin
        if (tmr_exp) begin
          state_d  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_V;
          cpu_d    = 1'b1;
          cpd_d    = 1'b1;
          pl_d     = 1'b1;
          mr_d     = 1'b0;
          // Pin release is the counter's count edge.
          if (op_q == OP_UP) begin
            sh_d    = bcd_up(shadow);
            wu_d    = (shadow == BCD_MAX);
            steps_d = steps_q - 1'b1;
          end else if (op_q == OP_DOWN) begin
            sh_d    = bcd_dn(shadow);
            wd_d    = (shadow == 4'd0);
            steps_d = steps_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tmr_exp) begin
          if (steps_q != '0) begin
            state_d  = S_ACTIVE;
            tmr_load = 1'b1;
            if (op_q == OP_UP) cpu_d = 1'b0;
            else               cpd_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= OP_UP;
      steps_q <= '0;
      cpu     <= 1'b1;
      cpd     <= 1'b1;
      pl_n    <= 1'b1;
      mr      <= 1'b0;
      p       <= 4'd0;
      shadow  <= 4'd0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
    end else begin
      state   <= state_d;
      op_q    <= op_d;
      steps_q <= steps_d;
      cpu     <= cpu_d;
      cpd     <= cpd_d;
      pl_n    <= pl_d;
      mr      <= mr_d;
      p       <= p_d;
      shadow  <= sh_d;
      wrap_up <= wu_d;
      wrap_dn <= wd_d;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_ACTIVE) || (state == S_GAP);
  assign done      = (state == S_DONE);

endmodule
